// File: rtl/mem_requester_pkg.sv
// Shared constants, encodings and payload types for the line-wide memory requester.
package mem_requester_pkg;

    localparam int unsigned ADDR_WIDTH  = 32;
    localparam int unsigned LINE_WIDTH  = 128;
    localparam int unsigned OFFSET_BITS = $clog2(LINE_WIDTH / 8);

    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((64'd1 << OFFSET_BITS) - 64'd1);

    typedef enum logic [2:0] {
        MR_IDLE  = 3'd0,
        MR_ISSUE = 3'd1,
        MR_WAIT  = 3'd2,
        MR_ACK   = 3'd3,
        MR_RESP  = 3'd4
    } mr_state_e;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef struct packed {
        logic                  op;
        logic [ADDR_WIDTH-1:0] addr;
        logic [LINE_WIDTH-1:0] data;
    } mem_req_t;

    // Offset bits are discarded rather than faulted.
    function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] addr);
        return addr & LINE_MASK;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter: combinational grant, pointer advances past the winner on accept.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant_c
);

    logic ptr_q;

    always_comb begin
        grant_c = 2'b00;
        case (req)
            2'b01:   grant_c = 2'b01;
            2'b10:   grant_c = 2'b10;
            2'b11:   grant_c = ptr_q ? 2'b10 : 2'b01;
            default: grant_c = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else if (accept) begin
            ptr_q <= grant_c[0];
        end
    end

endmodule

// File: rtl/mem_requester.sv
// Arbitrates instruction/data cache line requests and serialises them onto the line-wide memory port.
module mem_requester
    import mem_requester_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  c0_req_valid,
    input  logic                  c0_req_op,
    input  logic [ADDR_WIDTH-1:0] c0_req_addr,
    input  logic [LINE_WIDTH-1:0] c0_req_wdata,
    output logic                  c0_req_ready,
    output logic                  c0_resp_valid,
    output logic [LINE_WIDTH-1:0] c0_resp_rdata,
    input  logic                  c1_req_valid,
    input  logic                  c1_req_op,
    input  logic [ADDR_WIDTH-1:0] c1_req_addr,
    input  logic [LINE_WIDTH-1:0] c1_req_wdata,
    output logic                  c1_req_ready,
    output logic                  c1_resp_valid,
    output logic [LINE_WIDTH-1:0] c1_resp_rdata,
    output logic                  mem_enable,
    output logic                  mem_op,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_data_in,
    output logic                  mem_op_init,
    output logic                  mem_op_done,
    input  logic [LINE_WIDTH-1:0] mem_data_out,
    input  logic                  mem_data_ready
);

    mr_state_e             state_q, state_d;
    logic [1:0]            req_c, grant_c;
    logic                  accept_c;
    mem_req_t              win_c, req_q;
    logic                  gnt_q;
    logic [LINE_WIDTH-1:0] line_q;

    assign req_c    = {c1_req_valid, c0_req_valid};
    assign accept_c = (state_q == MR_IDLE) && (req_c != 2'b00);

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_c),
        .accept  (accept_c),
        .grant_c (grant_c)
    );

    assign c0_req_ready = (state_q == MR_IDLE) && grant_c[0];
    assign c1_req_ready = (state_q == MR_IDLE) && grant_c[1];

    // Payload of whichever client wins this cycle.
    always_comb begin
        win_c      = '0;
        win_c.op   = grant_c[1] ? c1_req_op : c0_req_op;
        win_c.addr = line_align(grant_c[1] ? c1_req_addr : c0_req_addr);
        win_c.data = grant_c[1] ? c1_req_wdata : c0_req_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stale data_ready outside WAIT/ACK is ignored by construction.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MR_IDLE:  if (req_c != 2'b00) state_d = MR_ISSUE;
            MR_ISSUE: state_d = MR_WAIT;
            MR_WAIT:  if (mem_data_ready) state_d = MR_ACK;
            MR_ACK:   if (!mem_data_ready) state_d = MR_RESP;
            MR_RESP:  state_d = MR_IDLE;
            default:  state_d = MR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q  <= '0;
            gnt_q  <= 1'b0;
            line_q <= '0;
        end else begin
            if (accept_c) begin
                req_q <= win_c;
                gnt_q <= grant_c[1];
            end
            if ((state_q == MR_WAIT) && mem_data_ready) begin
                line_q <= (req_q.op == OP_READ) ? mem_data_out : '0;
            end
        end
    end

    // Outputs decoded from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_enable    <= 1'b0;
            mem_op_init   <= 1'b0;
            mem_op_done   <= 1'b0;
            c0_resp_valid <= 1'b0;
            c1_resp_valid <= 1'b0;
            c0_resp_rdata <= '0;
            c1_resp_rdata <= '0;
        end else begin
            mem_enable    <= (state_d == MR_ISSUE) || (state_d == MR_WAIT);
            mem_op_init   <= (state_d == MR_ISSUE);
            mem_op_done   <= (state_d == MR_ACK);
            c0_resp_valid <= (state_d == MR_RESP) && !gnt_q;
            c1_resp_valid <= (state_d == MR_RESP) && gnt_q;
            if ((state_d == MR_RESP) && !gnt_q) c0_resp_rdata <= line_q;
            if ((state_d == MR_RESP) && gnt_q)  c1_resp_rdata <= line_q;
        end
    end

    assign mem_op      = req_q.op;
    assign mem_address = req_q.addr;
    assign mem_data_in = req_q.data;

endmodule

// File: tb/tb_mem_requester.sv
// Self-checking bench for mem_requester: responsive memory model plus an abstract arbitration/data reference.
module tb_mem_requester;
    import mem_requester_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         c0_req_valid = 1'b0, c0_req_op = 1'b0;
    logic [31:0]  c0_req_addr = '0;
    logic [127:0] c0_req_wdata = '0;
    logic         c0_req_ready, c0_resp_valid;
    logic [127:0] c0_resp_rdata;
    logic         c1_req_valid = 1'b0, c1_req_op = 1'b0;
    logic [31:0]  c1_req_addr = '0;
    logic [127:0] c1_req_wdata = '0;
    logic         c1_req_ready, c1_resp_valid;
    logic [127:0] c1_resp_rdata;
    logic         mem_enable, mem_op, mem_op_init, mem_op_done;
    logic [31:0]  mem_address;
    logic [127:0] mem_data_in;
    logic [127:0] mem_data_out = '0;
    logic         mem_data_ready;
    logic         model_ready = 1'b0, stale_ready = 1'b0;

    assign mem_data_ready = model_ready | stale_ready;

    always #5 clk = ~clk;

    mem_requester dut (
        .clk(clk), .rst_n(rst_n),
        .c0_req_valid(c0_req_valid), .c0_req_op(c0_req_op), .c0_req_addr(c0_req_addr),
        .c0_req_wdata(c0_req_wdata), .c0_req_ready(c0_req_ready),
        .c0_resp_valid(c0_resp_valid), .c0_resp_rdata(c0_resp_rdata),
        .c1_req_valid(c1_req_valid), .c1_req_op(c1_req_op), .c1_req_addr(c1_req_addr),
        .c1_req_wdata(c1_req_wdata), .c1_req_ready(c1_req_ready),
        .c1_resp_valid(c1_resp_valid), .c1_resp_rdata(c1_resp_rdata),
        .mem_enable(mem_enable), .mem_op(mem_op), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .mem_op_init(mem_op_init), .mem_op_done(mem_op_done),
        .mem_data_out(mem_data_out), .mem_data_ready(mem_data_ready)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] init_line(input logic [31:0] a);
        return {a ^ 32'h5A5A0F0F, ~a, a + 32'h1234, a ^ 32'hFFFF0000};
    endfunction

    // Memory model: data_ready sampled high L edges after the ISSUE edge, dropped
    // once op_done has been observed (hold+2) cycles.
    int           mem_lat = 5, mem_hold = 0;
    int           cnt = 0, done_seen = 0;
    logic         busy = 1'b0;
    logic [127:0] mem_store [logic [31:0]];
    int           init_count = 0, done_cycles = 0;
    logic         last_op = 1'b0;
    logic [31:0]  last_addr = '0;
    logic [127:0] last_din = '0;
    int           r_cnt [2] = '{0, 0};
    logic [127:0] r_data [2];
    int           r_cyc [2] = '{0, 0};

    always @(negedge clk) begin
        if (c0_resp_valid) begin r_cnt[0]++; r_data[0] = c0_resp_rdata; r_cyc[0] = cyc; end
        if (c1_resp_valid) begin r_cnt[1]++; r_data[1] = c1_resp_rdata; r_cyc[1] = cyc; end
        if (!rst_n) begin
            model_ready = 1'b0;
            busy = 1'b0;
        end else begin
            if (mem_op_done) done_cycles++;
            if (mem_op_init) begin
                init_count++;
                last_op = mem_op; last_addr = mem_address; last_din = mem_data_in;
                cnt = mem_lat; busy = 1'b1; done_seen = 0;
            end else if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    busy = 1'b0;
                    model_ready = 1'b1;
                    if (mem_op == OP_WRITE) begin
                        mem_store[mem_address] = mem_data_in;
                        mem_data_out = {$urandom, $urandom, $urandom, $urandom};
                    end else begin
                        mem_data_out = mem_store.exists(mem_address) ? mem_store[mem_address]
                                                                     : init_line(mem_address);
                    end
                end
            end else if (model_ready && mem_op_done) begin
                done_seen++;
                if (done_seen == mem_hold + 2) model_ready = 1'b0;
            end
        end
    end

    // Reference: line store, round-robin pointer (1 = client 1 favoured).
    logic [127:0] ref_store [logic [31:0]];
    logic         ptr_m = 1'b0;

    function automatic logic [127:0] ref_read(input logic [31:0] a);
        if (ref_store.exists(a)) return ref_store[a];
        return init_line(a);
    endfunction

    task automatic drive(input int c, input logic v, input logic op, input logic [31:0] a, input logic [127:0] d);
        if (c == 0) begin
            c0_req_valid = v; c0_req_op = op; c0_req_addr = a; c0_req_wdata = d;
        end else begin
            c1_req_valid = v; c1_req_op = op; c1_req_addr = a; c1_req_wdata = d;
        end
    endtask

    task automatic run_round(input logic [1:0] mask, input logic [1:0] ops,
                             input logic [31:0] a0, input logic [31:0] a1,
                             input logic [127:0] d0, input logic [127:0] d1);
        logic [1:0]   pend;
        int           win, got, c, acc_cyc, base_init, base_done, base_own, base_oth;
        logic         op;
        logic [31:0]  a, la;
        logic [127:0] d, exp;
        pend = mask;
        drive(0, mask[0], ops[0], a0, d0);
        drive(1, mask[1], ops[1], a1, d1);
        while (pend != 2'b00) begin
            win = (pend == 2'b11) ? (ptr_m ? 1 : 0) : (pend[1] ? 1 : 0);
            ptr_m = (win == 0);
            got = -1;
            for (int k = 0; k < 50 && got < 0; k++) begin
                @(negedge clk);
                if (c0_req_ready && c1_req_ready) got = 2;
                else if (c0_req_ready) got = 0;
                else if (c1_req_ready) got = 1;
            end
            check_i("grant", got, win);
            if (got != 0 && got != 1) begin
                drive(0, 1'b0, 1'b0, '0, '0);
                drive(1, 1'b0, 1'b0, '0, '0);
                return;
            end
            c = got;
            base_init = init_count; base_done = done_cycles;
            base_own = r_cnt[c]; base_oth = r_cnt[1-c];
            op = (c == 0) ? ops[0] : ops[1];
            a  = (c == 0) ? a0 : a1;
            d  = (c == 0) ? d0 : d1;
            @(posedge clk); #1;
            acc_cyc = cyc;
            drive(c, 1'b0, 1'b0, '0, '0);
            pend[c] = 1'b0;
            la = a - (a % 32'd16);
            if (op == OP_WRITE) begin
                ref_store[la] = d;
                exp = '0;
            end else begin
                exp = ref_read(la);
            end
            for (int k = 0; k < 300 && r_cnt[c] == base_own; k++) begin
                @(posedge clk); #1;
            end
            check_i("resp_count", r_cnt[c] - base_own, 1);
            check_i("other_resp_count", r_cnt[1-c] - base_oth, 0);
            check("resp_rdata", r_data[c], exp);
            check_i("latency", r_cyc[c] - acc_cyc, mem_lat + 3 + mem_hold);
            check_i("op_init_pulses", init_count - base_init, 1);
            check_i("op_done_cycles", done_cycles - base_done, mem_hold + 2);
            check("mem_op", 128'(last_op), 128'(op));
            check("mem_address", 128'(last_addr), 128'(la));
            if (op == OP_WRITE) check("mem_data_in", last_din, d);
            check("resp_single_pulse", 128'({c0_resp_valid, c1_resp_valid}), 128'(0));
            check("enable_idle", 128'(mem_enable), 128'(0));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] first_line;
        logic [31:0]  ra0, ra1;
        int           s_init, s_r0, s_r1;

        // Reset state
        #1;
        check("rst_enable", 128'(mem_enable), 128'(0));
        check("rst_op_init", 128'(mem_op_init), 128'(0));
        check("rst_op_done", 128'(mem_op_done), 128'(0));
        check("rst_address", 128'(mem_address), 128'(0));
        check("rst_data_in", mem_data_in, '0);
        check("rst_resp", 128'({c0_resp_valid, c1_resp_valid, mem_op}), 128'(0));
        check("rst_rdata0", c0_resp_rdata, '0);
        check("rst_ready", 128'({c0_req_ready, c1_req_ready}), 128'(0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single read with offset bits set
        first_line = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        mem_store[32'h10] = first_line;
        ref_store[32'h10] = first_line;
        mem_lat = 5; mem_hold = 0;
        run_round(2'b01, 2'b00, 32'h0000_0013, 32'h0, '0, '0);
        check("c0_first_line", c0_resp_rdata, first_line);

        // Write from client 1
        mem_lat = int'($urandom_range(1, 6));
        run_round(2'b10, 2'b10, 32'h0, 32'h40, '0, {4{32'hDEADBEEF}});
        check("c1_write_rdata", c1_resp_rdata, '0);
        check("c0_rdata_held", c0_resp_rdata, first_line);

        // Contention, twice, then a lone c0 followed by contention
        mem_lat = 3;
        run_round(2'b11, 2'b00, 32'h40, 32'h10, '0, '0);
        run_round(2'b11, 2'b11, 32'h84, 32'h9C, {4{$urandom}}, {4{$urandom}});
        run_round(2'b01, 2'b00, 32'h84, 32'h0, '0, '0);
        run_round(2'b11, 2'b00, 32'h9C, 32'h84, '0, '0);

        // Memory holds data_ready after op_done
        mem_hold = 3; mem_lat = 4;
        run_round(2'b01, 2'b00, 32'h40, 32'h0, '0, '0);
        mem_hold = 0;

        // Stale data_ready in IDLE
        s_init = init_count; s_r0 = r_cnt[0]; s_r1 = r_cnt[1];
        stale_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("stale_enable", 128'({mem_enable, mem_op_done}), 128'(0));
        check_i("stale_no_init", init_count - s_init, 0);
        check_i("stale_no_resp", (r_cnt[0] - s_r0) + (r_cnt[1] - s_r1), 0);
        stale_ready = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of WAIT
        mem_lat = 20;
        drive(0, 1'b1, OP_READ, 32'h100, '0);
        for (int k = 0; k < 20 && !c0_req_ready; k++) @(negedge clk);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, '0, '0);
        repeat (4) @(posedge clk);
        #1;
        check("wait_enable", 128'({mem_enable, mem_op_init}), 128'(2'b10));
        s_init = init_count; s_r0 = r_cnt[0]; s_r1 = r_cnt[1];
        #2 rst_n = 1'b0;
        #1;
        check("arst_enable", 128'(mem_enable), 128'(0));
        check("arst_done_resp", 128'({mem_op_done, c0_resp_valid, c1_resp_valid}), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        ptr_m = 1'b0;
        mem_lat = 2;
        repeat (30) @(posedge clk);
        #1;
        check_i("arst_no_resp", (r_cnt[0] - s_r0) + (r_cnt[1] - s_r1), 0);
        check_i("arst_no_retry", init_count - s_init, 0);
        run_round(2'b11, 2'b00, 32'h200, 32'h210, '0, '0);

        // Randomised rounds
        for (int i = 0; i < 10; i++) begin
            mem_lat  = int'($urandom_range(1, 6));
            mem_hold = int'($urandom_range(0, 2));
            ra0 = 32'h1000 + 32'($urandom_range(0, 5)) * 32'd16 + 32'($urandom_range(0, 15));
            ra1 = 32'h1000 + 32'($urandom_range(0, 5)) * 32'd16 + 32'($urandom_range(0, 15));
            run_round(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), ra0, ra1,
                      {$urandom, $urandom, $urandom, $urandom},
                      {$urandom, $urandom, $urandom, $urandom});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
